// File: rtl/vga_pkg.sv
// Shared timing constants, lock-FSM state type and CRC helper for the VGA
// sync decoder.
package vga_pkg;

  localparam int CW          = 11;
  localparam int H_TOTAL     = 1041;
  localparam int H_SYNC      = 120;
  localparam int V_TOTAL     = 667;
  localparam int V_SYNC      = 6;
  localparam int H_ACTIVE    = 800;
  localparam int V_ACTIVE    = 600;
  localparam int LOCK_FRAMES = 2;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    LOCKED
  } sync_state_t;

  // CRC-16-CCITT over one 24-bit pixel, MSB first.
  function automatic logic [15:0] crc16_px(input logic [15:0] crc, input logic [23:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 23; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/vga_edge_det.sv
// Two-stage input register with single-cycle rise/fall pulses derived from
// the two registered samples.
module vga_edge_det #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic s1,
  output logic rise,
  output logic fall
);

  logic s2;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign rise = s1 & ~s2;
  assign fall = s2 & ~s1;

endmodule

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing monitor: pixel coordinates, line/frame measurement
// and a lock FSM. Define VGA_DEC_CRC_EN to add the per-frame pixel CRC.
module vga_sync_decoder
  import vga_pkg::*;
#(
  parameter int H_TOTAL     = vga_pkg::H_TOTAL,
  parameter int H_SYNC      = vga_pkg::H_SYNC,
  parameter int V_TOTAL     = vga_pkg::V_TOTAL,
  parameter int V_SYNC      = vga_pkg::V_SYNC,
  parameter int LOCK_FRAMES = vga_pkg::LOCK_FRAMES,
  parameter int CW          = vga_pkg::CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic          blank_in,
  input  logic [7:0]    red_in,
  input  logic [7:0]    green_in,
  input  logic [7:0]    blue_in,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          pix_valid,
  output logic [7:0]    pix_r,
  output logic [7:0]    pix_g,
  output logic [7:0]    pix_b,
  output logic          frame_start,
  output logic          locked,
  output logic          timing_err,
  output logic [CW-1:0] h_period,
  output logic [CW-1:0] v_period,
  output logic [7:0]    err_count
`ifdef VGA_DEC_CRC_EN
  ,
  output logic [15:0]   frame_crc
`endif
);

  localparam int GW = $clog2(LOCK_FRAMES + 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0] H_TOTAL_C = CW'(H_TOTAL);
  localparam logic [CW-1:0] H_SYNC_C  = CW'(H_SYNC);
  localparam logic [CW-1:0] V_TOTAL_C = CW'(V_TOTAL);
  localparam logic [CW-1:0] V_SYNC_C  = CW'(V_SYNC);
  localparam logic [GW-1:0] LOCK_C    = GW'(LOCK_FRAMES);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic hs1, he, ls;
  logic vs1, ve, fs;
  logic bl1, be, bf;
  logic [23:0]   rgb_s1;
  logic [CW-1:0] h_cnt, v_cnt, hs_w, hs_meas, vs_w, vs_meas, h_line;
  logic [GW-1:0] good_cnt, good_inc;
  logic          match;
  sync_state_t   state;

  vga_edge_det u_hs (.clk(clk), .rst(rst), .d(hsync_in), .s1(hs1), .rise(he), .fall(ls));
  vga_edge_det u_vs (.clk(clk), .rst(rst), .d(vsync_in), .s1(vs1), .rise(ve), .fall(fs));
  vga_edge_det u_bl (.clk(clk), .rst(rst), .d(blank_in), .s1(bl1), .rise(be), .fall(bf));

  assign h_line   = sat_inc(h_cnt);
  assign good_inc = good_cnt + 1'b1;
  // Frame checks use the line count just completed, not last frame's v_period.
  assign match = (v_cnt == V_TOTAL_C) && (h_period == H_TOTAL_C) &&
                 (hs_meas == H_SYNC_C) && (vs_meas == V_SYNC_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_s1 <= '0;   h_cnt <= '0;    h_period <= '0; hs_w <= '0; hs_meas <= '0;
      v_cnt <= '0;    v_period <= '0; vs_w <= '0;     vs_meas <= '0;
      pix_x <= '0;    pix_y <= '0;    pix_valid <= 1'b0;
      pix_r <= '0;    pix_g <= '0;    pix_b <= '0;    frame_start <= 1'b0;
    end else begin
      rgb_s1 <= {red_in, green_in, blue_in};

      if (ls) begin
        h_cnt    <= '0;
        h_period <= h_line;
      end else begin
        h_cnt <= sat_inc(h_cnt);
      end
      if (he) begin
        hs_meas <= hs_w;
        hs_w    <= '0;
      end else if (!hs1) begin
        hs_w <= sat_inc(hs_w);
      end

      if (fs) begin
        v_period <= v_cnt;
        v_cnt    <= '0;
      end else if (ls) begin
        v_cnt <= sat_inc(v_cnt);
      end
      if (ve) begin
        vs_meas <= vs_w;
        vs_w    <= '0;
      end else if (ls && !vs1) begin
        vs_w <= sat_inc(vs_w);
      end

      pix_valid             <= !bl1;
      {pix_r, pix_g, pix_b} <= rgb_s1;
      // The first active cycle of a line holds column 0; later ones advance.
      if (be)              pix_x <= '0;
      else if (!bl1 && !bf) pix_x <= sat_inc(pix_x);
      if (fs)                       pix_y <= '0;
      else if (be && pix_x != '0)   pix_y <= sat_inc(pix_y);

      frame_start <= fs;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SEARCH;
      good_cnt   <= '0;
      locked     <= 1'b0;
      timing_err <= 1'b0;
      err_count  <= '0;
    end else begin
      timing_err <= 1'b0;
      if (h_cnt == CNT_MAX) begin
        state    <= SEARCH;
        good_cnt <= '0;
        locked   <= 1'b0;
      end else begin
        case (state)
          SEARCH: if (fs) begin
            state    <= MEASURE;
            good_cnt <= '0;
          end
          MEASURE: if (fs) begin
            if (!match) begin
              good_cnt <= '0;
            end else if (good_inc == LOCK_C) begin
              state    <= LOCKED;
              locked   <= 1'b1;
              good_cnt <= '0;
            end else begin
              good_cnt <= good_inc;
            end
          end
          LOCKED: if ((ls && h_line != H_TOTAL_C) || (fs && !match)) begin
            timing_err <= 1'b1;
            if (err_count != 8'hFF) err_count <= err_count + 1'b1;
            locked   <= 1'b0;
            state    <= MEASURE;
            good_cnt <= '0;
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

`ifdef VGA_DEC_CRC_EN
  logic [15:0] crc_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_acc   <= CRC_INIT;
      frame_crc <= '0;
    end else if (fs) begin
      frame_crc <= crc_acc;
      crc_acc   <= CRC_INIT;
    end else if (pix_valid) begin
      crc_acc <= crc16_px(crc_acc, {pix_r, pix_g, pix_b});
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Self-checking bench for vga_sync_decoder on scaled-down timing; pixels are
// scoreboarded against the generator, lock/error behaviour checked per frame.
module tb_vga_sync_decoder;

  localparam int CW  = 11;
  localparam int HT  = 41, HA = 30, HSB = 33, HS = 6;
  localparam int VT  = 27, VA = 20, VSB = 22, VS = 3;
  localparam int LF  = 2;

  typedef struct {
    int          x;
    int          y;
    logic [23:0] rgb;
    int          cyc;
  } pix_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          hsync_in, vsync_in, blank_in;
  logic [7:0]    red_in, green_in, blue_in;
  logic [CW-1:0] pix_x, pix_y, h_period, v_period;
  logic          pix_valid, frame_start, locked, timing_err;
  logic [7:0]    pix_r, pix_g, pix_b, err_count;
`ifdef VGA_DEC_CRC_EN
  logic [15:0]   frame_crc;
  logic [15:0]   const_crc;
`endif

  int          tests = 0, fails = 0;
  int          cyc = 0;
  pix_t        sb_q[$];
  logic [15:0] crc_q[$];
  logic [15:0] crc_model = 16'hFFFF;
  int          frame_no = 0, frames_sent = 0, fs_seen = 0, err_pulses = 0, pix_cnt = 0;
  int          fs_cyc = 0, ls_err_cyc = 0, last_err_cyc = -1;

  vga_sync_decoder #(
    .H_TOTAL(HT), .H_SYNC(HS), .V_TOTAL(VT), .V_SYNC(VS), .LOCK_FRAMES(LF), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .frame_start(frame_start), .locked(locked), .timing_err(timing_err),
    .h_period(h_period), .v_period(v_period), .err_count(err_count)
`ifdef VGA_DEC_CRC_EN
    , .frame_crc(frame_crc)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] crc_px(input logic [15:0] c, input logic [23:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 23; i >= 0; i--) begin
      logic fb;
      fb = r[15];
      r  = r << 1;
      if (fb ^ d[i]) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  // One generated frame; vsync falls at line VSB, h=0, lasting vs_lines lines.
  task automatic run_frame(input int vs_lines, input int short_line, input bit const_col,
                           input int alter_x);
    for (int v = 0; v < VT; v++) begin
      int ht;
      ht = (v == short_line) ? HT - 1 : HT;
      for (int h = 0; h < ht; h++) begin
        logic [23:0] col;
        @(posedge clk);
        #1;
        hsync_in = !(h >= HSB && h < HSB + HS);
        vsync_in = !(v >= VSB && v < VSB + vs_lines);
        blank_in = !(h < HA && v < VA);
        col = const_col ? 24'hFF7F0F : {h[7:0], v[7:0], frame_no[7:0]};
        if (h == alter_x && v == 0) col = 24'h00FF00;
        {red_in, green_in, blue_in} = col;
        if (!blank_in) begin
          sb_q.push_back('{x: h, y: v, rgb: col, cyc: cyc});
          crc_model = crc_px(crc_model, col);
        end
        if (v == VSB && h == 0) begin
          fs_cyc = cyc + 2;
          crc_q.push_back(crc_model);
          crc_model = 16'hFFFF;
          frames_sent++;
        end
        if (short_line >= 0 && v == short_line + 1 && h == HSB) ls_err_cyc = cyc + 2;
      end
    end
    frame_no++;
  endtask

  always @(negedge clk) begin
    pix_t e;
    if (!rst) begin
      if (pix_valid) begin
        if (sb_q.size() == 0) begin
          check("pix_unexpected", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check("pix", {pix_x, pix_y, pix_r, pix_g, pix_b, 16'(cyc)},
                {11'(e.x), 11'(e.y), e.rgb, 16'(e.cyc + 2)});
        end
        pix_cnt++;
      end
      if (frame_start) begin
        fs_seen++;
        check("fs_cyc", 64'(cyc), 64'(fs_cyc));
        check("pix_per_frame", 64'(pix_cnt), 64'(HA * VA));
        pix_cnt = 0;
`ifdef VGA_DEC_CRC_EN
        if (crc_q.size() == 0) check("crc_unexpected", 64'd1, 64'd0);
        else                   check("frame_crc", 64'(frame_crc), 64'(crc_q.pop_front()));
`endif
      end
      if (timing_err) begin
        err_pulses++;
        last_err_cyc = cyc;
      end
    end
  end

  initial begin
    rst = 1'b1;
    hsync_in = 1'b1; vsync_in = 1'b1; blank_in = 1'b1;
    {red_in, green_in, blue_in} = '0;
`ifdef VGA_DEC_CRC_EN
    const_crc = 16'hFFFF;
    for (int i = 0; i < HA * VA; i++) const_crc = crc_px(const_crc, 24'hFF7F0F);
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_locked", 64'(locked), 64'd0);
    check("rst_pix", 64'({pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b}), 64'd0);
    check("rst_periods", 64'({h_period, v_period}), 64'd0);
    check("rst_flags", 64'({frame_start, timing_err, err_count}), 64'd0);
    rst = 1'b0;

    // Nominal timing: lock on the second full frame after the first FS.
    run_frame(VS, -1, 1'b0, -1);  check("lock_f0", 64'(locked), 64'd0);
    run_frame(VS, -1, 1'b0, -1);  check("lock_f1", 64'(locked), 64'd0);
    run_frame(VS, -1, 1'b0, -1);  check("lock_f2", 64'(locked), 64'd1);
    check("h_period", 64'(h_period), 64'(HT));
    check("v_period", 64'(v_period), 64'(VT));
    check("err_count_nominal", 64'(err_count), 64'd0);

    // One short line while locked.
    run_frame(VS, 5, 1'b0, -1);
    check("short_err_pulses", 64'(err_pulses), 64'd1);
    check("short_err_at_ls", 64'(last_err_cyc), 64'(ls_err_cyc));
    check("short_err_count", 64'(err_count), 64'd1);
    check("short_unlock", 64'(locked), 64'd0);
    run_frame(VS, -1, 1'b0, -1);  check("short_relock", 64'(locked), 64'd1);

    // Narrow vsync pulse: flagged at the following frame start.
    run_frame(VS - 1, -1, 1'b0, -1);
    check("vs_narrow_locked", 64'(locked), 64'd1);
    check("vs_narrow_no_err", 64'(err_pulses), 64'd1);
    run_frame(VS, -1, 1'b0, -1);
    check("vs_err_pulses", 64'(err_pulses), 64'd2);
    check("vs_err_at_fs", 64'(last_err_cyc), 64'(fs_cyc));
    check("vs_err_count", 64'(err_count), 64'd2);
    check("vs_unlock", 64'(locked), 64'd0);
    run_frame(VS, -1, 1'b0, -1);  check("vs_relock_early", 64'(locked), 64'd0);
    run_frame(VS, -1, 1'b0, -1);  check("vs_relock", 64'(locked), 64'd1);

    // hsync held high: watchdog drops lock silently near 2047 clocks.
    repeat (1900) @(posedge clk);
    #1;
    check("wd_early_locked", 64'(locked), 64'd1);
    repeat (200) @(posedge clk);
    #1;
    check("wd_unlock", 64'(locked), 64'd0);
    check("wd_no_err", 64'(err_pulses), 64'd2);
    check("wd_err_count", 64'(err_count), 64'd2);

    // Resume from SEARCH with constant-colour frames.
    run_frame(VS, -1, 1'b1, -1);
`ifdef VGA_DEC_CRC_EN
    check("crc_const_1", 64'(frame_crc), 64'(const_crc));
`endif
    run_frame(VS, -1, 1'b1, -1);
    check("wd_relock_early", 64'(locked), 64'd0);
`ifdef VGA_DEC_CRC_EN
    check("crc_const_2", 64'(frame_crc), 64'(const_crc));
`endif
    run_frame(VS, -1, 1'b1, 7);
    check("wd_relock", 64'(locked), 64'd1);
`ifdef VGA_DEC_CRC_EN
    check("crc_altered_differs", 64'(frame_crc != const_crc), 64'd1);
`endif

    repeat (10) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    check("frame_start_count", 64'(fs_seen), 64'(frames_sent));
`ifdef VGA_DEC_CRC_EN
    check("crc_drained", 64'(crc_q.size()), 64'd0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
Receive-side counterpart of the VGA timing generator; it sits on the same clock as that generator.
Inputs: hsync/vsync/blank/RGB, as driven to the DAC, or a looped-back or second source.
Recovers pixel coordinates, measures line and frame timing, and runs a lock state machine against the expected 800x600 timing.
Used as an in-system timing monitor and as the capture front end for the verification bench.

Parameters:
H_TOTAL, 1041, expected clocks between consecutive hsync falling edges
H_SYNC, 120, expected hsync low width in clocks
V_TOTAL, 667, expected lines between consecutive vsync falling edges
V_SYNC, 6, expected vsync low width in lines
LOCK_FRAMES, 2, consecutive matching frames required to assert locked
CW, 11, width of all counters and coordinates

Ports:
clk  in  1  system clock (50 MHz); all logic on posedge
rst  in  1  asynchronous, active-high reset
hsync_in  in  1  horizontal sync, active low
vsync_in  in  1  vertical sync, active low
blank_in  in  1  combined blank, high outside the active area
red_in/green_in/blue_in  in  8 each  pixel colour
pix_x  out  CW  active-area column
pix_y  out  CW  active-area row
pix_valid  out  1  pix_* and pix_r/g/b valid this cycle
pix_r/pix_g/pix_b  out  8 each  registered colour aligned to pix_x/pix_y
frame_start  out  1  one-cycle pulse on a detected vsync falling edge
locked  out  1  timing matches the parameters
timing_err  out  1  one-cycle pulse on a mismatch while LOCKED
h_period  out  CW  last measured line period in clocks
v_period  out  CW  last measured frame period in lines
err_count  out  8  saturating count of timing_err pulses

Behaviour:
- Reset values: all outputs 0; all counters 0; FSM in SEARCH.
- Input path:
  - Stage 1 registers all inputs; stage 2 holds the previous sample.
  - LS (line start) = hsync stage2=1 and stage1=0.
  - FS (frame start) = the same condition on vsync.
  - HE / BE = rising edges of hsync / blank.
- Horizontal measurement:
  - h_cnt clears to 0 on LS; otherwise increments, saturating at 2^CW-1.
  - On LS: h_period <= h_cnt+1, saturating.
  - hs_w counts clocks with hsync low; it is captured into hs_meas on HE.
- Vertical measurement:
  - v_cnt increments on LS.
  - On FS: v_period <= v_cnt, then v_cnt <= 0. FS wins over LS in the same cycle.
  - vs_w counts LS events with vsync low; it is captured on the vsync rising edge.
- Coordinates:
  - pix_x increments on each cycle with stage1 blank low and clears on BE.
  - pix_y increments on BE when pix_x != 0, and clears on FS.
  - pix_valid = registered not-blank.
  - Total latency from input to pix_* is 2 cycles.
  - Coordinates saturate at 2^CW-1; they never wrap.
- FSM:
  - SEARCH -> MEASURE on the first FS; good_cnt=0.
  - MEASURE, on each FS:
    - Match means v_period==V_TOTAL, h_period==H_TOTAL, hs_meas==H_SYNC and vs_meas==V_SYNC.
    - Match increments good_cnt; a mismatch clears good_cnt.
    - When good_cnt reaches LOCK_FRAMES -> LOCKED with locked=1.
  - LOCKED: on each LS with h_period!=H_TOTAL, or each FS with any mismatch:
    - timing_err pulses for one cycle; err_count+1, saturating at 255.
    - locked=0; -> MEASURE with good_cnt=0.
  - Watchdog, any state: h_cnt saturation (no LS for 2^CW-1 clocks) -> SEARCH, locked=0, no timing_err.
- frame_start pulses on every FS in every state.
- Reset mid-frame: everything returns to reset values. The first partial line or frame after reset only seeds the counters and is never compared.

Optional Feature:
VGA_DEC_CRC_EN:
- When defined:
  - A CRC-16-CCITT (poly 0x1021, init 0xFFFF) accumulates {pix_r,pix_g,pix_b}, 24 bits per valid pixel, one pixel per cycle.
  - On FS, the running CRC is latched to output frame_crc[15:0] and the accumulator is re-initialised.
  - frame_crc resets to 0.
- When undefined: no CRC logic and no frame_crc port.

Decomposition:
- Shared package vga_pkg holds:
  - the timing constants (H_TOTAL, H_SYNC, V_TOTAL, V_SYNC, H_ACTIVE=800, V_ACTIVE=600);
  - the FSM state enum (SEARCH, MEASURE, LOCKED);
  - the CRC polynomial/init constants.
- One natural sub-module, vga_edge_det: 2-stage register with rise/fall pulses, instantiated for hsync, vsync and blank.

Test Plan:
- Reset, then drive nominal 800x600 timing (1041x667) -> locked=0 through frame 1; locked=1 after the 2nd full frame following the first FS; h_period=1041, v_period=667, err_count=0.
- Nominal timing, observe active area -> first pix_valid after FS has pix_x=0, pix_y=0; last has pix_x=799, pix_y=599; exactly 480000 pix_valid cycles per frame; RGB delayed 2 cycles.
- Locked, then one line shortened to 1000 clocks -> timing_err pulses once at the next LS; locked=0; err_count=1; locked=1 again 2 frames later.
- Locked, vsync width changed to 5 lines -> timing_err at that FS; relock only after 2 clean frames.
- hsync held high -> after 2047 clocks the FSM is in SEARCH, locked=0, no timing_err; resuming timing relocks.
- With VGA_DEC_CRC_EN, a constant colour 0xFF7F0F frame -> frame_crc equals the bench CRC model and is identical on consecutive frames; one altered pixel changes it.
